vga_sync_gen: RTL and testbench

//  Raster timing generator for the Pong display path; sits directly upstream of the ball,

---
 rtl/vga_sync_gen_if.sv | 24 ++
 rtl/vga_sync_gen.sv | 98 +++++++++
 tb/tb_vga_sync_gen.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// Raster output bundle of the VGA timing generator plus its count enable.
// The generator side is the slave (drives the raster); the consumer is the master.
interface vga_sync_gen_if #(
    parameter int unsigned FCNT_W = 16
);
    logic              en;
    logic [9:0]        x;
    logic [9:0]        y;
    logic              vga_on;
    logic              hsync;
    logic              vsync;
    logic              frame_tick;
    logic [FCNT_W-1:0] frame_count;

    modport master (
        output en,
        input  x, y, vga_on, hsync, vsync, frame_tick, frame_count
    );

    modport slave (
        input  en,
        output x, y, vga_on, hsync, vsync, frame_tick, frame_count
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel coordinates, visible flag, active-low syncs,
// a once-per-frame tick and a free-running frame counter, all registered together.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned FCNT_W    = 16
) (
    input logic           clk25M,
    input logic           reset,
    vga_sync_gen_if.slave vga_io
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] XMax       = 10'(H_TOTAL - 1);
    localparam logic [9:0] YMax       = 10'(V_TOTAL - 1);
    localparam logic [9:0] XVis       = 10'(H_VISIBLE);
    localparam logic [9:0] YVis       = 10'(V_VISIBLE);
    localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] YTick      = 10'(V_VISIBLE + 1);

    if (H_TOTAL > 1024) begin : g_h_total_chk
        $error("vga_sync_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_total_chk
        $error("vga_sync_gen: V_TOTAL exceeds 1024");
    end

    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic              vga_on_q, vga_on_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              tick_q, tick_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    // Decode is taken from the next position so flags land in step with x/y.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        fcnt_d = fcnt_q;
        tick_d = 1'b0;
        if (vga_io.en) begin
            if (x_q == XMax) begin
                x_d = '0;
                if (y_q == YMax) begin
                    y_d    = '0;
                    fcnt_d = fcnt_q + 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
            tick_d = (x_d == '0) && (y_d == YTick);
        end
        vga_on_d = (x_d < XVis) && (y_d < YVis);
        hsync_d  = !((x_d >= HSyncStart) && (x_d < HSyncEnd));
        vsync_d  = !((y_d >= VSyncStart) && (y_d < VSyncEnd));
    end

    always_ff @(posedge clk25M) begin
        if (!reset) begin
            x_q      <= '0;
            y_q      <= '0;
            vga_on_q <= 1'b1;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            tick_q   <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            vga_on_q <= vga_on_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            tick_q   <= tick_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign vga_io.x           = x_q;
    assign vga_io.y           = y_q;
    assign vga_io.vga_on      = vga_on_q;
    assign vga_io.hsync       = hsync_q;
    assign vga_io.vsync       = vsync_q;
    assign vga_io.frame_tick  = tick_q;
    assign vga_io.frame_count = fcnt_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: full-size instance for line-level timing, shrunken instance for frame-level
// behaviour (tick, stall, counter wrap) checked against a cycle model via a queue.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic rst_s = 1'b0;
    always #20 clk = ~clk;

    vga_sync_gen_if #(.FCNT_W(16)) big_if ();
    vga_sync_gen_if #(.FCNT_W(4))  sm_if ();

    vga_sync_gen #(.FCNT_W(16)) u_big (
        .clk25M (clk),
        .reset  (rst_b),
        .vga_io (big_if)
    );

    // Small raster: 25 x 15 = 375 cycles per frame, tick at (0,9).
    vga_sync_gen #(
        .H_VISIBLE (16), .H_FRONT (2), .H_SYNC (4), .H_BACK (3),
        .V_VISIBLE (8),  .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
        .FCNT_W    (4)
    ) u_sm (
        .clk25M (clk),
        .reset  (rst_s),
        .vga_io (sm_if)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       on;
        logic       hs;
        logic       vs;
        logic       tk;
        logic [3:0] fc;
    } exp_t;

    exp_t sb[$];
    int   m_x = 0, m_y = 0, m_fc = 0;
    bit   m_tk = 0;

    typedef struct {
        int unsigned adv;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        on;
        logic        hs;
        logic        vs;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        exp_t ex, act;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            ex  = sb.pop_front();
            act = '{x: sm_if.x, y: sm_if.y, on: sm_if.vga_on, hs: sm_if.hsync,
                    vs: sm_if.vsync, tk: sm_if.frame_tick, fc: sm_if.frame_count};
            total++;
            if (act !== ex) begin
                bad++;
                $display("FAIL sb: got x=%0d y=%0d on=%b hs=%b vs=%b tk=%b fc=%0d want x=%0d y=%0d on=%b hs=%b vs=%b tk=%b fc=%0d",
                         act.x, act.y, act.on, act.hs, act.vs, act.tk, act.fc,
                         ex.x, ex.y, ex.on, ex.hs, ex.vs, ex.tk, ex.fc);
            end
        end
    endtask

    // Drive the small instance for one edge and queue what it must show afterwards.
    task automatic sm_step(input bit r, input bit e);
        exp_t ex;
        rst_s    = r;
        sm_if.en = e;
        if (!r) begin
            m_x = 0; m_y = 0; m_fc = 0; m_tk = 0;
        end else if (e) begin
            if (m_x == 24) begin
                m_x = 0;
                if (m_y == 14) begin
                    m_y  = 0;
                    m_fc = (m_fc + 1) % 16;
                end else m_y++;
            end else m_x++;
            m_tk = (m_x == 0) && (m_y == 9);
        end else m_tk = 0;
        ex.x  = 10'(m_x);
        ex.y  = 10'(m_y);
        ex.on = (m_x < 16) && (m_y < 8);
        ex.hs = !((m_x >= 18) && (m_x < 22));
        ex.vs = !((m_y >= 10) && (m_y < 12));
        ex.tk = m_tk;
        ex.fc = 4'(m_fc);
        sb.push_back(ex);
        cycle();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        int hs_cnt, hs_first, hs_last, on_cnt, tk_cnt, vs_cnt, last_tk;

        tbl[0] = '{0,   10'd0,   10'd0, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{639, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{1,   10'd640, 10'd0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{15,  10'd655, 10'd0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1,   10'd656, 10'd0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{95,  10'd751, 10'd0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1,   10'd752, 10'd0, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{47,  10'd799, 10'd0, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{1,   10'd0,   10'd1, 1'b1, 1'b1, 1'b1};

        sm_if.en  = 1'b0;
        big_if.en = 1'b1;
        rst_b     = 1'b0;
        repeat (3) cycle();
        chk("big_rst_x", int'(big_if.x), 0);
        chk("big_rst_y", int'(big_if.y), 0);
        chk("big_rst_on", int'(big_if.vga_on), 1);
        chk("big_rst_hs", int'(big_if.hsync), 1);
        chk("big_rst_vs", int'(big_if.vsync), 1);
        chk("big_rst_tk", int'(big_if.frame_tick), 0);
        chk("big_rst_fc", int'(big_if.frame_count), 0);
        rst_b = 1'b1;

        foreach (tbl[i]) begin
            repeat (tbl[i].adv) cycle();
            chk($sformatf("tbl%0d_x", i), int'(big_if.x), int'(tbl[i].x));
            chk($sformatf("tbl%0d_y", i), int'(big_if.y), int'(tbl[i].y));
            chk($sformatf("tbl%0d_on", i), int'(big_if.vga_on), int'(tbl[i].on));
            chk($sformatf("tbl%0d_hs", i), int'(big_if.hsync), int'(tbl[i].hs));
            chk($sformatf("tbl%0d_vs", i), int'(big_if.vsync), int'(tbl[i].vs));
        end

        hs_cnt = 0; hs_first = -1; hs_last = -1; on_cnt = 0; tk_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (!big_if.hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(big_if.x);
                hs_last = int'(big_if.x);
            end
            if (big_if.vga_on) on_cnt++;
            if (big_if.frame_tick) tk_cnt++;
            cycle();
        end
        chk("line_hs_cnt", hs_cnt, 96);
        chk("line_hs_first", hs_first, 656);
        chk("line_hs_last", hs_last, 751);
        chk("line_on_cnt", on_cnt, 640);
        chk("line_tk_cnt", tk_cnt, 0);
        chk("line_end_x", int'(big_if.x), 0);
        chk("line_end_y", int'(big_if.y), 2);

        repeat (400) cycle();
        chk("mid_x", int'(big_if.x), 400);
        rst_b = 1'b0;
        cycle();
        chk("midrst_x", int'(big_if.x), 0);
        chk("midrst_y", int'(big_if.y), 0);
        chk("midrst_on", int'(big_if.vga_on), 1);
        chk("midrst_hs", int'(big_if.hsync), 1);
        chk("midrst_fc", int'(big_if.frame_count), 0);
        rst_b = 1'b1;

        // Small instance: reset (first cycle with en low), then one full frame.
        sm_step(0, 0);
        sm_step(0, 1);
        sm_step(0, 1);
        tk_cnt = 0; vs_cnt = 0;
        for (int i = 0; i < 375; i++) begin
            sm_step(1, 1);
            if (sm_if.frame_tick) tk_cnt++;
            if (!sm_if.vsync) vs_cnt++;
        end
        chk("frame_tk_cnt", tk_cnt, 1);
        chk("frame_vs_cnt", vs_cnt, 50);
        chk("frame_fc", int'(sm_if.frame_count), 1);

        repeat (225) sm_step(1, 1);
        chk("tick_at_0_9", int'(sm_if.frame_tick), 1);
        tk_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            sm_step(1, 0);
            if (sm_if.frame_tick) tk_cnt++;
        end
        chk("stall_tk_cnt", tk_cnt, 0);
        chk("stall_y", int'(sm_if.y), 9);
        sm_step(1, 1);
        chk("resume_x", int'(sm_if.x), 1);
        chk("resume_tk", int'(sm_if.frame_tick), 0);

        repeat (100) sm_step(1, 1);
        sm_step(0, 1);
        chk("sm_rst_fc", int'(sm_if.frame_count), 0);
        sm_step(0, 0);

        // Sixteen frames: counter 1..15 then 0, tick period constant.
        tk_cnt = 0; last_tk = -1;
        for (int i = 1; i <= 16 * 375; i++) begin
            sm_step(1, 1);
            if (sm_if.frame_tick) begin
                if (last_tk >= 0) chk("tick_period", i - last_tk, 375);
                last_tk = i;
                tk_cnt++;
            end
            if (i % 375 == 0) chk("fc_seq", int'(sm_if.frame_count), (i / 375) % 16);
        end
        chk("wrap_tk_cnt", tk_cnt, 16);

        for (int i = 0; i < 500; i++) sm_step(1, $urandom_range(0, 3) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
